// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter through a single output register.
// Grants are locked per message, with a round-robin pointer and a forced release after MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 sresetn,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    input  logic                 req0_last,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    input  logic                 req1_last,
    output logic                 req1_ready,
    output logic                 tx_valid,
    output logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_ready,
    output logic [1:0]           grant
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic [7:0]             burst_q, burst_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;

    logic out_free;
    logic acc0, acc1;

    // The output register can take a new byte when empty or draining this cycle.
    assign out_free = !tx_valid_q || tx_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        case (state_q)
            IDLE: begin
                burst_d = 8'd0;
                if (req0_valid && req1_valid) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                req0_ready = out_free;
                acc0       = req0_valid && out_free;
                if (acc0) begin
                    burst_d = burst_q + 8'd1;
                    if (req0_last || burst_q == BURST_END) begin
                        state_d = IDLE;
                        ptr_d   = 1'b1;
                    end
                end
            end
            GRANT1: begin
                req1_ready = out_free;
                acc1       = req1_valid && out_free;
                if (acc1) begin
                    burst_d = burst_q + 8'd1;
                    if (req1_last || burst_q == BURST_END) begin
                        state_d = IDLE;
                        ptr_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accepted bytes overwrite the output register in the same edge that drains it.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (acc0) begin
            tx_valid_d = 1'b1;
            tx_data_d  = req0_data;
        end else if (acc1) begin
            tx_valid_d = 1'b1;
            tx_data_d  = req1_data;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            burst_q    <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant    = (state_q == GRANT0) ? 2'b01 :
                      (state_q == GRANT1) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed reset/latency cases, then random two-source traffic
// checked by a per-source scoreboard and a message-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       sresetn;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [1:0] grant;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    uart_tx_arbiter #(.DATA_BITS(8), .MAX_BURST(MB)) dut (
        .clk(clk), .sresetn(sresetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor state: previous-cycle samples plus the model's pointer and burst count.
    bit         mptr = 1'b0;
    int         mburst = 0;
    bit         p_rel = 1'b0, p_rst = 1'b1, p_v0 = 1'b0, p_v1 = 1'b0;
    bit         p_txv = 1'b0, p_txr = 1'b0;
    logic [7:0] p_txd = 8'h00;
    logic [1:0] p_grant = 2'b00;
    bit         run_open = 1'b0;
    bit         run_src = 1'b0;
    int         run_len = 0;

    always @(negedge clk) begin
        logic [1:0] exp_g;
        logic [8:0] e;
        bit         s, acc, acc_last;
        if (mon_en && !p_rst) begin
            if (p_grant == 2'b00) begin
                exp_g = (p_v0 && p_v1) ? (mptr ? 2'b10 : 2'b01) :
                        p_v0 ? 2'b01 : p_v1 ? 2'b10 : 2'b00;
                check("arbitration", 32'(grant), 32'(exp_g));
            end else begin
                check("grant_lock_release", 32'(grant), p_rel ? 32'd0 : 32'(p_grant));
                if (p_rel) mptr = (p_grant == 2'b01);
            end
            if (p_txv && !p_txr) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(p_txd));
            end
        end
        if (mon_en) begin
            check("ready0", 32'(req0_ready), 32'(grant == 2'b01 && (!tx_valid || tx_ready)));
            check("ready1", 32'(req1_ready), 32'(grant == 2'b10 && (!tx_valid || tx_ready)));
            if (tx_valid && tx_ready) begin
                s = tx_data[7];
                if ((s ? exp_q1.size() : exp_q0.size()) == 0) begin
                    check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    e = s ? exp_q1.pop_front() : exp_q0.pop_front();
                    check(s ? "tx_byte_src1" : "tx_byte_src0", 32'(tx_data), 32'(e[7:0]));
                    if (run_open && s != run_src) begin
                        check("contiguity", 32'(s), 32'(run_src));
                    end
                    if (!run_open) begin
                        run_open = 1'b1;
                        run_src  = s;
                        run_len  = 0;
                    end
                    run_len++;
                    if (e[8] || run_len == MB) run_open = 1'b0;
                end
            end
        end
        acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        acc_last = req0_ready ? req0_last : req1_last;
        if (grant == 2'b00) mburst = 0;
        p_rel = 1'b0;
        if (acc) begin
            mburst++;
            p_rel = acc_last || (mburst == MB);
        end
        p_grant = grant;
        p_v0    = req0_valid;
        p_v1    = req1_valid;
        p_rst   = !sresetn;
        p_txv   = tx_valid;
        p_txr   = tx_ready;
        p_txd   = tx_data;
    end

    task automatic drive_src(input bit s, input int nmsg);
        int seq = 0;
        for (int m = 0; m < nmsg; m++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                bit         lst;
                bit         acc = 1'b0;
                int         cyc = 0;
                if ($urandom_range(0, 3) == 0) begin
                    if (s) req1_valid = 1'b0; else req0_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) tick();
                end
                d   = {s, 7'(seq)};
                lst = (b == len - 1);
                if (s) begin
                    req1_valid = 1'b1; req1_data = d; req1_last = lst;
                    exp_q1.push_back({lst, d});
                end else begin
                    req0_valid = 1'b1; req0_data = d; req0_last = lst;
                    exp_q0.push_back({lst, d});
                end
                while (!acc && cyc < 300) begin
                    @(negedge clk);
                    acc = s ? req1_ready : req0_ready;
                    if (!acc) begin
                        tick();
                        cyc++;
                    end
                end
                if (!acc) check("accept_timeout", 32'(cyc), 32'd0);
                tick();
                seq++;
            end
        end
        if (s) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    initial begin
        sresetn = 1'b0; tx_ready = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        sresetn = 1'b1;

        // Single requester, three-byte message, one-cycle latency.
        tick();
        req0_valid = 1'b1; req0_data = 8'h41;
        tick();
        @(negedge clk);
        check("single_grant", 32'(grant), 32'd1);
        check("single_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_data = 8'h42;
        @(negedge clk);
        check("single_tx41_v", 32'(tx_valid), 32'd1);
        check("single_tx41", 32'(tx_data), 32'h41);
        tick();
        req0_data = 8'h43; req0_last = 1'b1;
        @(negedge clk);
        check("single_tx42", 32'(tx_data), 32'h42);
        tick();
        req0_valid = 1'b0; req0_last = 1'b0;
        @(negedge clk);
        check("single_tx43", 32'(tx_data), 32'h43);
        check("single_release", 32'(grant), 32'd0);
        tick();
        @(negedge clk);
        check("single_drained", 32'(tx_valid), 32'd0);

        // Reset while a byte is stuck in the output register.
        tx_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h55;
        tick();
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        check("stuck_valid", 32'(tx_valid), 32'd1);
        check("stuck_data", 32'(tx_data), 32'h55);
        check("stuck_ready1", 32'(req1_ready), 32'd0);
        sresetn = 1'b0;
        tick();
        sresetn = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h66; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b1;
        @(negedge clk);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check("midrst_ptr_req0", 32'(grant), 32'd1);
        tick();
        req0_valid = 1'b0; req0_last = 1'b0;
        @(negedge clk);
        check("midrst_tx66", 32'(tx_data), 32'h66);
        check("idle_gap", 32'(grant), 32'd0);
        tick();
        @(negedge clk);
        check("alt_grant1", 32'(grant), 32'd2);
        tick();
        req1_valid = 1'b0; req1_last = 1'b0;
        @(negedge clk);
        check("alt_tx77", 32'(tx_data), 32'h77);
        tick();

        // Random two-source traffic with random backpressure.
        sresetn = 1'b0;
        tick();
        tick();
        sresetn = 1'b1;
        mon_en = 1'b1;
        fork
            drive_src(1'b0, 12);
            drive_src(1'b1, 12);
            begin
                for (int c = 0; c < 3000; c++) begin
                    tx_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 40) == 0) begin
                        tx_ready = 1'b0;
                        repeat (5) tick();
                    end else begin
                        tick();
                    end
                end
                tx_ready = 1'b1;
            end
        join_any
        wait fork;
        tx_ready = 1'b1;
        for (int c = 0; c < 50 && (exp_q0.size() + exp_q1.size()) != 0; c++) tick();
        repeat (3) tick();
        check("drain_q0", 32'(exp_q0.size()), 32'd0);
        check("drain_q1", 32'(exp_q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
